// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte/packet handshake bundle between the UART receiver, the packet
// controller (master) and the payload consumer (slave).
interface uart_rx_pkt_ctrl_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       pkt_err;
    logic [1:0] err_code;

    modport master (
        input  rx_done, rx_data, out_ready,
        output rx_en, out_valid, out_data, out_last, pkt_err, err_code
    );

    modport slave (
        output rx_done, rx_data, out_ready,
        input  rx_en, out_valid, out_data, out_last, pkt_err, err_code
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames UART bytes as SYNC, LEN, payload, XOR checksum; buffers the payload
// and presents it only after the checksum has been verified.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    uart_rx_pkt_ctrl_if.master   bus
);
    localparam int CW    = $clog2(MAX_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int DEPTH = 1 << CW;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          rx_done_q;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] rd_q, rd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    chk_q, chk_d;
    logic          pkt_err_q, pkt_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          buf_we;
    logic [7:0]    buf_q [DEPTH];

    logic byte_ev;
    logic len_ok;
    logic timed;
    logic last;

    assign byte_ev = bus.rx_done & ~rx_done_q;
    assign len_ok  = (bus.rx_data != 8'd0) && (int'(bus.rx_data) <= MAX_LEN);
    assign timed   = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
    assign last    = (rd_q == len_q - CW'(1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        rd_d       = rd_q;
        timer_d    = timer_q;
        chk_d      = chk_q;
        pkt_err_d  = 1'b0;
        err_code_d = err_code_q;
        buf_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) state_d = HUNT;
            end
            HUNT: begin
                if (byte_ev && bus.rx_data == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
                if (byte_ev) begin
                    if (len_ok) begin
                        len_d   = bus.rx_data[CW-1:0];
                        chk_d   = bus.rx_data;
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = 2'd0;
                        state_d    = HUNT;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_ev) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ bus.rx_data;
                    idx_d  = idx_q + CW'(1);
                    if (idx_q + CW'(1) == len_q) state_d = CHECK;
                end
            end
            CHECK: begin
                if (byte_ev) begin
                    if (bus.rx_data == chk_q) begin
                        rd_d    = '0;
                        state_d = DRAIN;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = HUNT;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (last) begin
                        rd_d    = '0;
                        state_d = HUNT;
                    end else begin
                        rd_d = rd_q + CW'(1);
                    end
                end
                // The buffer is busy; the incoming byte is lost, draining goes on.
                if (byte_ev) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = 2'd3;
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte watchdog; a byte arriving on the limit cycle still wins.
        if (!timed) begin
            timer_d = '0;
        end else if (byte_ev) begin
            timer_d = '0;
        end else if (timer_q >= TLIM) begin
            timer_d    = '0;
            pkt_err_d  = 1'b1;
            err_code_d = 2'd2;
            state_d    = HUNT;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        if (!en) begin
            state_d    = IDLE;
            idx_d      = '0;
            rd_d       = '0;
            timer_d    = '0;
            pkt_err_d  = 1'b0;
            err_code_d = err_code_q;
            buf_we     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_done_q  <= 1'b1;
            len_q      <= '0;
            idx_q      <= '0;
            rd_q       <= '0;
            timer_q    <= '0;
            chk_q      <= '0;
            pkt_err_q  <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            rx_done_q  <= bus.rx_done;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rd_q       <= rd_d;
            timer_q    <= timer_d;
            chk_q      <= chk_d;
            pkt_err_q  <= pkt_err_d;
            err_code_q <= err_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[idx_q] <= bus.rx_data;
    end

    assign bus.rx_en     = (state_q != IDLE);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = (state_q == DRAIN) ? buf_q[rd_q] : 8'd0;
    assign bus.out_last  = (state_q == DRAIN) && last;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scenario bench for uart_rx_pkt_ctrl: expected payload bytes are queued as
// frames are sent and popped as the consumer side accepts them.
module tb_uart_rx_pkt_ctrl;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    uart_rx_pkt_ctrl_if bus ();

    uart_rx_pkt_ctrl #(
        .SYNC_BYTE  (8'hA5),
        .MAX_LEN    (8),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int valid_cycles = 0;
    logic [7:0] exp_data_q [$];
    logic       exp_last_q [$];
    logic [1:0] err_log [$];
    logic [7:0] pl_q [$];

    // Consumer-side scoreboard and error-pulse recorder, sampled mid-cycle.
    initial begin
        logic [7:0] ed;
        logic       el;
        forever begin
            @(negedge clk);
            if (bus.pkt_err === 1'b1) err_log.push_back(bus.err_code);
            if (bus.out_valid === 1'b1) valid_cycles++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got data=%h last=%b, expected no transfer",
                             bus.out_data, bus.out_last);
                end else begin
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (bus.out_data !== ed || bus.out_last !== el) begin
                        errors++;
                        $display("FAIL out_byte: got data=%h last=%b, expected data=%h last=%b",
                                 bus.out_data, bus.out_last, ed, el);
                    end else begin
                        $display("out byte %h last=%b ok", bus.out_data, bus.out_last);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        bus.rx_done = 1'b0;
        tick();
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
    endtask

    // Sends SYNC, LEN, pl_q and its checksum (LEN xor payload); optionally queues payload.
    task automatic send_frame(input bit expect_out);
        logic [7:0] chk;
        chk = 8'(pl_q.size());
        send_byte(8'hA5);
        send_byte(8'(pl_q.size()));
        foreach (pl_q[i]) begin
            chk ^= pl_q[i];
            send_byte(pl_q[i]);
            if (expect_out) begin
                exp_data_q.push_back(pl_q[i]);
                exp_last_q.push_back(i == pl_q.size() - 1);
            end
        end
        send_byte(chk);
        $display("frame len=%0d chk=%h sent", pl_q.size(), chk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_data_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d bytes still pending, expected 0", name, exp_data_q.size());
            exp_data_q.delete();
            exp_last_q.delete();
        end
        tick(2);
    endtask

    task automatic test_reset();
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        bus.out_ready = 1'b1;
        tick(3);
        checks++;
        if ({bus.rx_en, bus.out_valid, bus.out_last, bus.pkt_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got rx_en/valid/last/err=%b, expected 0000",
                     {bus.rx_en, bus.out_valid, bus.out_last, bus.pkt_err});
        end
        checks++;
        if (bus.out_data !== 8'h00 || bus.err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%h code=%0d, expected 00/0", bus.out_data, bus.err_code);
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (bus.rx_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_en0: got rx_en=%b, expected 0", bus.rx_en);
        end
        en = 1'b1;
        tick(2);
        checks++;
        if (bus.rx_en !== 1'b1) begin
            errors++;
            $display("FAIL hunt_en1: got rx_en=%b, expected 1", bus.rx_en);
        end
        $display("reset test done");
    endtask

    task automatic test_good_frame();
        err_log.delete();
        pl_q = '{8'h11, 8'h22, 8'h33};
        send_frame(1'b1);
        wait_drain("good");
        checks++;
        if (err_log.size() != 0) begin
            errors++;
            $display("FAIL good_noerr: got %0d error pulses, expected 0", err_log.size());
        end
    endtask

    task automatic test_len_err();
        err_log.delete();
        send_byte(8'hA5);
        send_byte(8'h09);
        tick(2);
        checks++;
        if (err_log.size() != 1 || err_log[0] !== 2'd0) begin
            errors++;
            $display("FAIL len_err: got %0d pulses code=%0d, expected 1 pulse code=0",
                     err_log.size(), err_log.size() ? err_log[0] : 2'd0);
        end
        err_log.delete();
        pl_q = '{8'h5A, 8'hC3};
        send_frame(1'b1);
        wait_drain("after_len");
        checks++;
        if (err_log.size() != 0) begin
            errors++;
            $display("FAIL after_len_noerr: got %0d pulses, expected 0", err_log.size());
        end
    endtask

    task automatic test_chk_err();
        int vc;
        err_log.delete();
        vc = valid_cycles;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'hFF);
        tick(4);
        checks++;
        if (err_log.size() != 1 || err_log[0] !== 2'd1) begin
            errors++;
            $display("FAIL chk_err: got %0d pulses code=%0d, expected 1 pulse code=1",
                     err_log.size(), err_log.size() ? err_log[0] : 2'd0);
        end
        checks++;
        if (valid_cycles != vc) begin
            errors++;
            $display("FAIL chk_novalid: got %0d out_valid cycles, expected 0", valid_cycles - vc);
        end
    endtask

    task automatic test_timeout();
        err_log.delete();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        tick(TIMEOUT + 20);
        checks++;
        if (err_log.size() != 1 || err_log[0] !== 2'd2) begin
            errors++;
            $display("FAIL timeout_err: got %0d pulses code=%0d, expected 1 pulse code=2",
                     err_log.size(), err_log.size() ? err_log[0] : 2'd0);
        end
        checks++;
        if (bus.rx_en !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got rx_en=%b valid=%b, expected 1/0", bus.rx_en, bus.out_valid);
        end
        pl_q = '{8'h01};
        send_frame(1'b1);
        wait_drain("after_timeout");
    endtask

    task automatic test_overrun();
        err_log.delete();
        bus.out_ready = 1'b0;
        pl_q = '{8'hAB, 8'hCD};
        send_frame(1'b1);
        tick(3);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hAB || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL ovr_hold: got valid=%b data=%h last=%b, expected 1/ab/0",
                     bus.out_valid, bus.out_data, bus.out_last);
        end
        send_byte(8'h55);
        tick(2);
        checks++;
        if (err_log.size() != 1 || err_log[0] !== 2'd3) begin
            errors++;
            $display("FAIL ovr_err: got %0d pulses code=%0d, expected 1 pulse code=3",
                     err_log.size(), err_log.size() ? err_log[0] : 2'd0);
        end
        checks++;
        if (bus.out_data !== 8'hAB || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_stable: got valid=%b data=%h, expected 1/ab", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        wait_drain("overrun");
    endtask

    task automatic test_reset_mid();
        err_log.delete();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h77);
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.rx_en, bus.out_valid, bus.out_last, bus.pkt_err} !== 4'b0000 ||
            bus.out_data !== 8'h00 || bus.err_code !== 2'd0) begin
            errors++;
            $display("FAIL midrst_outs: got en/valid/last/err=%b data=%h code=%0d, expected 0000/00/0",
                     {bus.rx_en, bus.out_valid, bus.out_last, bus.pkt_err}, bus.out_data, bus.err_code);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rx_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: got rx_en=%b, expected 0", bus.rx_en);
        end
        tick(4);
        checks++;
        if (err_log.size() != 0 || bus.out_valid !== 1'b0 || bus.rx_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_quiet: got pulses=%0d valid=%b rx_en=%b, expected 0/0/1",
                     err_log.size(), bus.out_valid, bus.rx_en);
        end
        pl_q = '{8'h7E};
        send_frame(1'b1);
        wait_drain("after_reset");
        checks++;
        if (err_log.size() != 0) begin
            errors++;
            $display("FAIL midrst_noerr: got %0d pulses, expected 0", err_log.size());
        end
    endtask

    task automatic test_back_to_back();
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(1'b1);
        wait_drain("max_len");
        pl_q = '{8'hF0};
        send_frame(1'b1);
        wait_drain("single");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_len_err();
        test_chk_err();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
